// File: rtl/ccff_loader_pkg.sv
// ccff_loader_pkg
// Shared types and default sizing for the ccff chain loader.
//   state_e        : loader FSM states (idle, shifting, tail flush, done pulse)
//   DEF_CHAIN_LEN  : default number of flops in the downstream configuration chain
//   DEF_WORD_W     : default configuration word width
package ccff_loader_pkg;

    localparam int unsigned DEF_CHAIN_LEN = 64;
    localparam int unsigned DEF_WORD_W    = 8;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StShift = 2'd1,
        StFlush = 2'd2,
        StDone  = 2'd3
    } state_e;

endpackage

// File: rtl/ccff_word_serializer.sv
// ccff_word_serializer
// Holds one configuration word and presents it MSB first, one bit per cycle, on a
// registered head/shift_en pair.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   load      : capture data; its MSB appears on head next cycle
//   data      : word to capture
//   step      : advance to the next lower bit of the held word
//   bit_en    : shift_en value for the bit presented by load/step
//   flush     : drive head=0 with shift_en=1 for one cycle
//   head      : serial bit to the chain head (registered)
//   shift_en  : head carries a valid chain bit (registered)
//   last_bit  : LSB of the held word is currently on head
// With no command, shift_en drops and head holds its value.
module ccff_word_serializer
    import ccff_loader_pkg::*;
#(
    parameter int unsigned WORD_W = DEF_WORD_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [WORD_W-1:0] data,
    input  logic              step,
    input  logic              bit_en,
    input  logic              flush,
    output logic              head,
    output logic              shift_en,
    output logic              last_bit
);

    localparam int unsigned IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

    logic [WORD_W-1:0] word_q;
    logic [IDX_W-1:0]  idx_q;
    logic              head_q;
    logic              shift_en_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            word_q     <= '0;
            idx_q      <= '0;
            head_q     <= 1'b0;
            shift_en_q <= 1'b0;
        end else if (load) begin
            word_q     <= data;
            idx_q      <= IDX_W'(WORD_W - 1);
            head_q     <= data[WORD_W-1];
            shift_en_q <= bit_en;
        end else if (step) begin
            idx_q      <= idx_q - 1'b1;
            head_q     <= word_q[idx_q - 1'b1];
            shift_en_q <= bit_en;
        end else if (flush) begin
            head_q     <= 1'b0;
            shift_en_q <= 1'b1;
        end else begin
            shift_en_q <= 1'b0;
        end
    end

    assign head     = head_q;
    assign shift_en = shift_en_q;
    assign last_bit = (idx_q == '0);

endmodule

// File: rtl/ccff_chain_loader.sv
// ccff_chain_loader
// Accepts configuration words over a valid/ready handshake and streams them MSB first
// into a ccff configuration chain, one bit per prog_clk cycle, gating the chain with
// ccff_shift_en. Bits past CHAIN_LEN are consumed without being shifted.
// Ports:
//   prog_clk, prog_reset           : clock, synchronous active-high reset
//   cfg_valid, cfg_data, cfg_last  : upstream word stream (cfg_last marks final word)
//   cfg_ready                      : word accepted this cycle (decoded from state only)
//   ccff_head, ccff_shift_en       : serial bit and shift gate to the chain
//   ccff_tail                      : chain tail, read back during flush
//   load_busy, load_done, load_err : status
// Build option: define CCFF_LOAD_CHECK_EN to check bitstream length and, after a
// correct-length load, flush the chain with zeros while comparing ccff_tail against
// the captured stream. Without it load_err is tied low and FLUSH is never entered.
module ccff_chain_loader
    import ccff_loader_pkg::*;
#(
    parameter int unsigned CHAIN_LEN = DEF_CHAIN_LEN,
    parameter int unsigned WORD_W    = DEF_WORD_W
) (
    input  logic              prog_clk,
    input  logic              prog_reset,
    input  logic              cfg_valid,
    input  logic [WORD_W-1:0] cfg_data,
    input  logic              cfg_last,
    output logic              cfg_ready,
    output logic              ccff_head,
    output logic              ccff_shift_en,
    input  logic              ccff_tail,
    output logic              load_busy,
    output logic              load_done,
    output logic              load_err
);

    localparam int unsigned CNT_W = $clog2(CHAIN_LEN + 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_base;
    logic             last_q, last_d;
    logic             rst_q;
    logic             busy_q, done_q;
    logic             take;
    logic             ser_load, ser_step, ser_flush, bit_en, last_bit;

`ifdef CCFF_LOAD_CHECK_EN
    logic                 err_q, err_d;
    logic                 ovf_q, ovf_d;
    logic [CHAIN_LEN-1:0] cmp_q, cmp_d;
    logic                 len_ok;
`endif

    // Ready is held low for the cycle after a reset edge so nothing is accepted
    // while the loader is still coming out of reset.
    always_comb begin
        case (state_q)
            StIdle:  cfg_ready = ~rst_q;
            StShift: cfg_ready = last_bit & ~last_q;
            default: cfg_ready = 1'b0;
        endcase
    end

    assign take = cfg_valid & cfg_ready;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        last_d    = last_q;
        ser_load  = 1'b0;
        ser_step  = 1'b0;
        ser_flush = 1'b0;
        bit_en    = 1'b0;
        // A transfer out of IDLE restarts the count from zero.
        cnt_base  = (state_q == StIdle) ? '0 : cnt_q;
`ifdef CCFF_LOAD_CHECK_EN
        err_d  = err_q;
        ovf_d  = ovf_q;
        cmp_d  = cmp_q;
        len_ok = (cnt_q == CNT_W'(CHAIN_LEN)) && !ovf_q;
        // Capture every bit that actually enters the chain; flush zeros push the
        // captured stream out in the same order the tail returns it.
        if (ccff_shift_en) begin
            cmp_d = {cmp_q[CHAIN_LEN-2:0], ccff_head};
        end
`endif

        case (state_q)
            StIdle: begin
                if (take) begin
                    state_d  = StShift;
                    ser_load = 1'b1;
                    last_d   = cfg_last;
`ifdef CCFF_LOAD_CHECK_EN
                    err_d    = 1'b0;
                    ovf_d    = 1'b0;
`endif
                end
            end
            StShift: begin
                if (!last_bit) begin
                    ser_step = 1'b1;
                end else if (last_q) begin
`ifdef CCFF_LOAD_CHECK_EN
                    if (len_ok) begin
                        state_d   = StFlush;
                        cnt_d     = '0;
                        ser_flush = 1'b1;
                    end else begin
                        state_d = StDone;
                        err_d   = 1'b1;
                    end
`else
                    state_d = StDone;
`endif
                end else if (take) begin
                    ser_load = 1'b1;
                    last_d   = cfg_last;
                end
            end
            StFlush: begin
`ifdef CCFF_LOAD_CHECK_EN
                if (ccff_tail != cmp_q[CHAIN_LEN-1]) begin
                    err_d = 1'b1;
                end
                if (cnt_q == CNT_W'(CHAIN_LEN - 1)) begin
                    state_d = StDone;
                end else begin
                    cnt_d     = cnt_q + 1'b1;
                    ser_flush = 1'b1;
                end
`else
                state_d = StIdle;
`endif
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Each new bit on head advances the saturating count; once the chain is full
        // further bits are presented with the shift gate closed.
        if (ser_load || ser_step) begin
            bit_en = (cnt_base != CNT_W'(CHAIN_LEN));
            if (bit_en) begin
                cnt_d = cnt_base + 1'b1;
            end
`ifdef CCFF_LOAD_CHECK_EN
            else begin
                ovf_d = 1'b1;
            end
`endif
        end
    end

    always_ff @(posedge prog_clk) begin
        rst_q <= prog_reset;
        if (prog_reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            busy_q  <= (state_d != StIdle);
            done_q  <= (state_d == StDone);
        end
    end

`ifdef CCFF_LOAD_CHECK_EN
    always_ff @(posedge prog_clk) begin
        if (prog_reset) begin
            err_q <= 1'b0;
            ovf_q <= 1'b0;
            cmp_q <= '0;
        end else begin
            err_q <= err_d;
            ovf_q <= ovf_d;
            cmp_q <= cmp_d;
        end
    end

    assign load_err = err_q;
`else
    logic unused_tail;
    assign unused_tail = ccff_tail;
    assign load_err    = 1'b0;
`endif

    assign load_busy = busy_q;
    assign load_done = done_q;

    ccff_word_serializer #(
        .WORD_W (WORD_W)
    ) u_serializer (
        .clk      (prog_clk),
        .rst      (prog_reset),
        .load     (ser_load),
        .data     (cfg_data),
        .step     (ser_step),
        .bit_en   (bit_en),
        .flush    (ser_flush),
        .head     (ccff_head),
        .shift_en (ccff_shift_en),
        .last_bit (last_bit)
    );

endmodule

// File: tb/tb_ccff_chain_loader.sv
// tb_ccff_chain_loader
// Scoreboard bench: word stimulus pushes the expected chain bits into a queue, a
// monitor pops and compares on every ccff_shift_en cycle. A behavioural chain model
// feeds ccff_tail back to the loader.
`timescale 1ns/1ps
module tb_ccff_chain_loader;

    localparam int L = 64;
    localparam int W = 8;
`ifdef CCFF_LOAD_CHECK_EN
    localparam int   FLUSH_N = L;
    localparam logic CHK     = 1'b1;
`else
    localparam int   FLUSH_N = 0;
    localparam logic CHK     = 1'b0;
`endif

    logic         prog_clk = 1'b0;
    logic         prog_reset;
    logic         cfg_valid;
    logic [W-1:0] cfg_data;
    logic         cfg_last;
    logic         cfg_ready;
    logic         ccff_head;
    logic         ccff_shift_en;
    logic         ccff_tail;
    logic         load_busy;
    logic         load_done;
    logic         load_err;

    int checks     = 0;
    int errors     = 0;
    int shift_cnt  = 0;
    int done_cnt   = 0;
    int load_bits  = 0;
    logic exp_q[$];

    logic [W-1:0] words [0:8] = '{8'hA5, 8'h3C, 8'hF0, 8'h0F, 8'h96,
                                  8'h69, 8'hC3, 8'h5A, 8'hE1};

    // Chain model: CHAIN_LEN flops clocked only when the gate is open.
    logic [L-1:0] chain = '0;
    logic         stuck = 1'b0;
    always @(posedge prog_clk) begin
        if (ccff_shift_en === 1'b1) chain <= {chain[L-2:0], ccff_head};
    end
    assign ccff_tail = stuck ? 1'b1 : chain[L-1];

    always #5 prog_clk = ~prog_clk;

    ccff_chain_loader #(
        .CHAIN_LEN (L),
        .WORD_W    (W)
    ) dut (
        .prog_clk      (prog_clk),
        .prog_reset    (prog_reset),
        .cfg_valid     (cfg_valid),
        .cfg_data      (cfg_data),
        .cfg_last      (cfg_last),
        .cfg_ready     (cfg_ready),
        .ccff_head     (ccff_head),
        .ccff_shift_en (ccff_shift_en),
        .ccff_tail     (ccff_tail),
        .load_busy     (load_busy),
        .load_done     (load_done),
        .load_err      (load_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every gated cycle must carry the next expected bit.
    always @(negedge prog_clk) begin : mon
        logic e;
        if (ccff_shift_en === 1'b1) begin
            shift_cnt++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL head_unexpected: got shift_en=1 head=%b expected no shift", ccff_head);
            end else begin
                e = exp_q.pop_front();
                if (ccff_head !== e) begin
                    errors++;
                    $display("FAIL head_bit%0d: got %b expected %b", shift_cnt, ccff_head, e);
                end
            end
        end
        if (load_done === 1'b1) begin
            done_cnt++;
            checks++;
            if (cfg_ready !== 1'b0 || load_busy !== 1'b1) begin
                errors++;
                $display("FAIL done_status: got ready=%b busy=%b expected ready=0 busy=1",
                         cfg_ready, load_busy);
            end
        end
    end

    task automatic do_reset(input bit check_vals);
        prog_reset = 1'b1;
        cfg_valid  = 1'b0;
        cfg_data   = '0;
        cfg_last   = 1'b0;
        @(posedge prog_clk); #1;
        if (check_vals) begin
            check("rst_ready", cfg_ready, 0);
            check("rst_head", ccff_head, 0);
            check("rst_shift_en", ccff_shift_en, 0);
            check("rst_busy", load_busy, 0);
            check("rst_done", load_done, 0);
            check("rst_err", load_err, 0);
        end
        @(posedge prog_clk); #1;
        prog_reset = 1'b0;
        exp_q.delete();
        @(posedge prog_clk); #1;
        if (check_vals) check("rst_ready_after", cfg_ready, 1);
    endtask

    // Push the word's in-chain bits, then hold it until a handshake completes.
    task automatic send_word(input logic [W-1:0] data, input logic last, input bit toggle);
        logic rdy, v, ph;
        for (int b = W - 1; b >= 0; b--) begin
            if (load_bits < L) begin
                exp_q.push_back(data[b]);
                load_bits++;
            end
        end
        cfg_data = data;
        cfg_last = last;
        ph = 1'b1;
        for (int c = 0; c < 200; c++) begin
            cfg_valid = toggle ? ph : 1'b1;
            ph = ~ph;
            @(negedge prog_clk);
            rdy = cfg_ready;
            v   = cfg_valid;
            @(posedge prog_clk); #1;
            if (rdy === 1'b1 && v === 1'b1) begin
                cfg_valid = 1'b0;
                return;
            end
        end
        cfg_valid = 1'b0;
        check("send_timeout", 1, 0);
    endtask

    task automatic run_load(input string tag, input int n, input bit toggle,
                            input bit flush, input logic exp_err);
        int s0, d0;
        bit got;
        s0 = shift_cnt;
        d0 = done_cnt;
        load_bits = 0;
        for (int i = 0; i < n; i++) send_word(words[i], (i == n - 1), toggle);
        if (flush) begin
            for (int i = 0; i < FLUSH_N; i++) exp_q.push_back(1'b0);
        end
        got = 1'b0;
        for (int c = 0; c < 600 && !got; c++) begin
            @(posedge prog_clk); #1;
            if (load_done === 1'b1) got = 1'b1;
        end
        check({tag, "_done_seen"}, got, 1);
        check({tag, "_err"}, load_err, exp_err);
        @(posedge prog_clk); #1;
        check({tag, "_idle_busy"}, load_busy, 0);
        check({tag, "_idle_ready"}, cfg_ready, 1);
        check({tag, "_done_pulse_len"}, load_done, 0);
        check({tag, "_shift_total"}, shift_cnt - s0, flush ? L + FLUSH_N : L);
        check({tag, "_queue_empty"}, exp_q.size(), 0);
        check({tag, "_done_count"}, done_cnt - d0, 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        int s0, d0;
        bit got;

        do_reset(1'b1);

        // Exact-length load, continuous valid.
        run_load("basic", 8, 1'b0, 1'b1, 1'b0);
        // Valid toggling: one stall per word boundary, same bits.
        run_load("toggle", 8, 1'b1, 1'b1, 1'b0);
        // 72 bits: only 64 reach the chain.
        run_load("overlen", 9, 1'b0, 1'b0, CHK);
        // Next IDLE transfer clears the sticky error.
        run_load("reload", 8, 1'b0, 1'b1, 1'b0);

        // Reset while bit 20 (in word 3) is on the head.
        load_bits = 0;
        s0 = shift_cnt;
        d0 = done_cnt;
        for (int i = 0; i < 3; i++) send_word(words[i], 1'b0, 1'b0);
        got = 1'b0;
        for (int c = 0; c < 100 && !got; c++) begin
            @(negedge prog_clk); #1;
            if (shift_cnt - s0 >= 20) got = 1'b1;
        end
        check("abort_bit20_reached", got, 1);
        prog_reset = 1'b1;
        @(posedge prog_clk); #1;
        check("abort_ready", cfg_ready, 0);
        check("abort_head", ccff_head, 0);
        check("abort_shift_en", ccff_shift_en, 0);
        check("abort_busy", load_busy, 0);
        check("abort_done", load_done, 0);
        check("abort_err", load_err, 0);
        exp_q.delete();
        @(posedge prog_clk); #1;
        prog_reset = 1'b0;
        @(posedge prog_clk); #1;
        check("abort_ready_after", cfg_ready, 1);
        repeat (20) begin
            @(posedge prog_clk); #1;
        end
        check("abort_no_done", done_cnt - d0, 0);
        check("abort_shift_total", shift_cnt - s0, 20);

`ifdef CCFF_LOAD_CHECK_EN
        // Stuck tail: flush readback must disagree with the captured stream.
        stuck = 1'b1;
        run_load("stuck", 8, 1'b0, 1'b1, 1'b1);
        stuck = 1'b0;
        run_load("good_chain", 8, 1'b0, 1'b1, 1'b0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ccff_chain_loader.md
CCFF_CHAIN_LOADER -- requirements
Module: ccff_chain_loader

Interface
REQ-001 SHALL have parameter CHAIN_LEN, default 64: number of configuration flip-flops in the downstream ccff chain (≥8).
REQ-002 SHALL have parameter WORD_W, default 8: configuration word width in bits.
REQ-003 prog_clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 prog_reset  input  1  reset, synchronous, active-high.
REQ-005 cfg_valid  input  1  upstream word valid.
REQ-006 cfg_data  input  WORD_W  configuration word, MSB shifted first.
REQ-007 cfg_last  input  1  marks final word of a bitstream, qualified by cfg_valid.
REQ-008 cfg_ready  output  1  loader accepts the word this cycle.
REQ-009 ccff_head  output  1  serial bit to the head of the configuration chain.
REQ-010 ccff_shift_en  output  1  high exactly in cycles where ccff_head carries a valid bit; drives the external prog_clk gate.
REQ-011 ccff_tail  input  1  chain tail, used only under REQ-030.
REQ-012 load_busy, load_done, load_err  output  1 each  status.

Function
REQ-013 Transfer SHALL occur in a cycle where cfg_valid and cfg_ready are both high; cfg_data and cfg_last SHALL be held stable by upstream until then.
REQ-014 FSM states SHALL be IDLE, SHIFT, FLUSH, DONE.
REQ-015 IDLE: cfg_ready=1; transfer moves to SHIFT and clears the bit counter and load_err.
REQ-016 Bits of an accepted word SHALL appear on ccff_head starting the cycle after transfer, MSB first, one bit per cycle, ccff_shift_en=1.
REQ-017 SHIFT: cfg_ready SHALL be high only while the last bit (LSB) of the held word is on ccff_head, so back-to-back words stream with no bubble.
REQ-018 If no new word is available when the LSB completes, ccff_shift_en SHALL drop to 0 and ccff_head hold its last value until the next transfer.
REQ-019 A running bit counter, width $clog2(CHAIN_LEN+1), SHALL saturate at CHAIN_LEN; bits beyond CHAIN_LEN SHALL be consumed with ccff_shift_en=0.
REQ-020 After the LSB of the cfg_last word, FSM SHALL enter DONE for one cycle: load_done=1, cfg_ready=0, then IDLE.
REQ-021 load_busy SHALL be 1 in SHIFT, FLUSH and DONE, 0 in IDLE.
REQ-022 cfg_valid in DONE SHALL be ignored (not accepted) until IDLE.
REQ-023 All outputs SHALL be registered; no combinational path from inputs to outputs except cfg_ready from state.

Reset
REQ-024 prog_reset sampled high SHALL force IDLE, counters to 0, held word to 0 on the next edge.
REQ-025 Reset values: cfg_ready=0 during reset, 1 the cycle after; ccff_head=0, ccff_shift_en=0, load_busy=0, load_done=0, load_err=0.
REQ-026 Reset mid-SHIFT SHALL abort the load; the partially shifted chain is not restored and no load_done pulse is issued.

Configuration
REQ-027 Macro CCFF_LOAD_CHECK_EN SHALL enable bitstream length checking.
REQ-028 With it: at the cfg_last word's completion, bits-accepted ≠ CHAIN_LEN SHALL set load_err, sticky until next IDLE transfer or reset; load_done still pulses.
REQ-029 Without it: load_err SHALL be tied 0 and FLUSH never entered.
REQ-030 With it: after a correct-length load, FSM SHALL enter FLUSH for CHAIN_LEN cycles with ccff_shift_en=1, ccff_head=0, sampling ccff_tail; ccff_tail≠prior-shifted bit in order sets load_err. Loader SHALL store the stream in a CHAIN_LEN-bit compare register.

Structure
REQ-031 Package ccff_loader_pkg SHALL hold the FSM state enum and default CHAIN_LEN/WORD_W constants.
REQ-032 Sub-module ccff_word_serializer (held word, 3-bit bit index, head/shift_en registers) SHALL be used; FSM and counters stay in the top.

Verification
REQ-033 Reset, send 8 words 0xA5..., last on 8th, CHAIN_LEN=64 -> 64 cycles shift_en=1, head matches MSB-first, load_done pulse, load_err=0.
REQ-034 cfg_valid toggled every other cycle -> shift_en gaps aligned to stalls, bit order intact, total 64 shifted bits.
REQ-035 Send 9 words (72 bits) -> exactly 64 shift_en cycles; with CCFF_LOAD_CHECK_EN load_err=1.
REQ-036 Assert prog_reset at bit 20 of word 3 -> next cycle all outputs at reset values, no load_done.
REQ-037 CCFF_LOAD_CHECK_EN, chain model with one stuck tail bit -> FLUSH 64 cycles, load_err=1; correct chain -> load_err=0.
